fifo_sync_ram_1p: RTL and testbench

- Two independent primitives sharing one clock and reset: a synchronous valid/ready FIFO and a single-port synchronous RAM.
- Used in flash bank emulation:
  - The FIFO buffers command payloads, e.g. Width = command struct width, Depth 2, Pass 0.
  - RAM instances hold data and info pages.
- FIFO and RAM share no state.

---
 rtl/fifo_sync_ram_1p.sv | 119 +++++++++++
 tb/tb_fifo_sync_ram_1p.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_ram_1p.sv
// Synchronous valid/ready FIFO with optional empty pass-through, plus an independent
// single-port synchronous RAM with grouped write mask. The two halves share only clock and reset.
module fifo_sync_ram_1p #(
    parameter int FWidth           = 16,
    parameter int FPass            = 1,
    parameter int FDepth           = 4,
    parameter int MWidth           = 32,
    parameter int MDepth           = 128,
    parameter int MDataBitsPerMask = 1,
    localparam int DepthW          = $clog2(FDepth + 1),
    localparam int AddrW           = $clog2(MDepth)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [FWidth-1:0] wdata_i,
    output logic [DepthW-1:0] depth_o,
    output logic              full_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [FWidth-1:0] rdata_o,
    output logic              err_o,
    input  logic              m_req_i,
    input  logic              m_write_i,
    input  logic [AddrW-1:0]  m_addr_i,
    input  logic [MWidth-1:0] m_wdata_i,
    input  logic [MWidth-1:0] m_wmask_i,
    output logic [MWidth-1:0] m_rdata_o,
    input  logic [9:0]        m_cfg_i,
    output logic [7:0]        m_cfg_rsp_o
);

    localparam int  PtrW   = (FDepth > 1) ? $clog2(FDepth) : 1;
    localparam int  Groups = MWidth / MDataBitsPerMask;
    localparam bit  Pass   = (FPass != 0);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    logic [FWidth-1:0] fifo_mem [FDepth];
    logic [PtrW-1:0]   wptr, rptr;
    logic [DepthW-1:0] count;
    logic              empty, push, pop, bypass_pop, wr_en, rd_en;

    assign empty    = (count == '0);
    assign full_o   = (count == DepthW'(FDepth));
    assign wready_o = !full_o;
    assign rvalid_o = !empty || (Pass && wvalid_i);
    assign push     = wvalid_i && wready_o;
    assign pop      = rvalid_o && rready_i;
    // An empty pass-through FIFO hands the write straight to the reader; nothing is stored.
    assign bypass_pop = Pass && empty && pop;
    assign wr_en      = push && !bypass_pop;
    assign rd_en      = pop && !empty;
    assign depth_o    = count;
    assign err_o      = 1'b0;

    always_comb begin
        rdata_o = '0;
        if (!empty)    rdata_o = fifo_mem[rptr];
        else if (Pass) rdata_o = wdata_i;
    end

    // Stage p0: pointer and occupancy update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= ptr_inc(wptr);
            if (rd_en) rptr <= ptr_inc(rptr);
            count <= count + DepthW'(wr_en) - DepthW'(rd_en);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !clr_i) fifo_mem[wptr] <= wdata_i;
    end

    logic [MWidth-1:0] ram [MDepth];
    logic [MWidth-1:0] m_rdata_p1;
    logic              in_range;

    assign in_range = ({1'b0, m_addr_i} < (AddrW + 1)'(MDepth));

    always_ff @(posedge clk_i) begin
        if (m_req_i && m_write_i && in_range) begin
            for (int k = 0; k < Groups; k++) begin
                if (m_wmask_i[k*MDataBitsPerMask])
                    ram[m_addr_i][k*MDataBitsPerMask +: MDataBitsPerMask] <=
                        m_wdata_i[k*MDataBitsPerMask +: MDataBitsPerMask];
            end
        end
    end

    // Stage p1: registered read port, held on writes and idle cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_rdata_p1 <= '0;
        end else if (m_req_i && !m_write_i) begin
            m_rdata_p1 <= in_range ? ram[m_addr_i] : '0;
        end
    end

    assign m_rdata_o   = m_rdata_p1;
    assign m_cfg_rsp_o = 8'h00;

    logic unused_ok;
    assign unused_ok = ^{m_cfg_i, m_wmask_i};

endmodule

// File: tb/tb_fifo_sync_ram_1p.sv
// Directed bench: FIFO without pass-through (depth 2) plus byte-masked RAM on one instance,
// pass-through FIFO behaviour on a second instance.
module tb_fifo_sync_ram_1p;

  logic clk, rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // instance A: FPass=0, FDepth=2, RAM 32b x 12 with byte mask
  logic        clr, wvalid, rready;
  logic [7:0]  wdata;
  logic        a_wready, a_full, a_rvalid, a_err;
  logic [1:0]  a_depth;
  logic [7:0]  a_rdata;
  logic        m_req, m_write;
  logic [3:0]  m_addr;
  logic [31:0] m_wdata, m_wmask, m_rdata;
  logic [9:0]  cfg;
  logic [7:0]  a_cfg_rsp;

  // instance B: FPass=1, FDepth=2, RAM idle
  logic        b_clr, b_wvalid, b_rready;
  logic [15:0] b_wdata;
  logic        b_wready, b_full, b_rvalid, b_err;
  logic [1:0]  b_depth;
  logic [15:0] b_rdata;
  logic        b_m_req, b_m_write;
  logic [6:0]  b_m_addr;
  logic [31:0] b_m_wdata, b_m_wmask, b_m_rdata;
  logic [7:0]  b_cfg_rsp;

  fifo_sync_ram_1p #(.FWidth(8), .FPass(0), .FDepth(2), .MWidth(32), .MDepth(12),
                     .MDataBitsPerMask(8)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .wvalid_i(wvalid), .wready_o(a_wready),
    .wdata_i(wdata), .depth_o(a_depth), .full_o(a_full), .rvalid_o(a_rvalid),
    .rready_i(rready), .rdata_o(a_rdata), .err_o(a_err), .m_req_i(m_req),
    .m_write_i(m_write), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wmask_i(m_wmask),
    .m_rdata_o(m_rdata), .m_cfg_i(cfg), .m_cfg_rsp_o(a_cfg_rsp)
  );

  fifo_sync_ram_1p #(.FWidth(16), .FPass(1), .FDepth(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr), .wvalid_i(b_wvalid), .wready_o(b_wready),
    .wdata_i(b_wdata), .depth_o(b_depth), .full_o(b_full), .rvalid_o(b_rvalid),
    .rready_i(b_rready), .rdata_o(b_rdata), .err_o(b_err), .m_req_i(b_m_req),
    .m_write_i(b_m_write), .m_addr_i(b_m_addr), .m_wdata_i(b_m_wdata),
    .m_wmask_i(b_m_wmask), .m_rdata_o(b_m_rdata), .m_cfg_i(cfg), .m_cfg_rsp_o(b_cfg_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    if (!done) begin
      total++;
      bad++;
      $error("FAIL timeout: directed sequence did not complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst_n = 1'b1;
    clr = 0; wvalid = 0; rready = 0; wdata = '0;
    m_req = 0; m_write = 0; m_addr = '0; m_wdata = '0; m_wmask = '0; cfg = 10'h3A5;
    b_clr = 0; b_wvalid = 0; b_rready = 0; b_wdata = '0;
    b_m_req = 0; b_m_write = 0; b_m_addr = '0; b_m_wdata = '0; b_m_wmask = '0;

    #1 rst_n = 1'b0;
    #1;
    total++;
    if (a_depth !== 2'd0 || a_full !== 1'b0 || a_rvalid !== 1'b0 || a_rdata !== 8'h00 ||
        a_wready !== 1'b1 || a_err !== 1'b0 || m_rdata !== 32'h0 || a_cfg_rsp !== 8'h00) begin
      bad++;
      $error("FAIL reset_state depth=%0h full=%0b rvalid=%0b rdata=%0h wready=%0b err=%0b m_rdata=%0h cfg_rsp=%0h",
             a_depth, a_full, a_rvalid, a_rdata, a_wready, a_err, m_rdata, a_cfg_rsp);
    end
    total++;
    if (a_depth !== 2'd0) begin bad++; $error("FAIL rst_depth observed=%0h", a_depth); end
    total++;
    if (a_full !== 1'b0) begin bad++; $error("FAIL rst_full observed=%0h", a_full); end
    total++;
    if (a_rvalid !== 1'b0) begin bad++; $error("FAIL rst_rvalid observed=%0h", a_rvalid); end
    total++;
    if (a_rdata !== 8'h00) begin bad++; $error("FAIL rst_rdata observed=%0h", a_rdata); end
    total++;
    if (a_wready !== 1'b1) begin bad++; $error("FAIL rst_wready observed=%0h", a_wready); end
    total++;
    if (a_err !== 1'b0) begin bad++; $error("FAIL rst_err observed=%0h", a_err); end
    total++;
    if (m_rdata !== 32'h0) begin bad++; $error("FAIL rst_m_rdata observed=%0h", m_rdata); end
    total++;
    if (a_cfg_rsp !== 8'h00) begin bad++; $error("FAIL rst_cfg_rsp observed=%0h", a_cfg_rsp); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // fill a depth-2 FIFO
    wvalid = 1; wdata = 8'h0A;
    tick;
    total++;
    if (a_depth !== 2'd1) begin bad++; $error("FAIL push1_depth observed=%0h", a_depth); end
    total++;
    if (a_rvalid !== 1'b1) begin bad++; $error("FAIL push1_rvalid observed=%0h", a_rvalid); end
    total++;
    if (a_rdata !== 8'h0A) begin bad++; $error("FAIL push1_rdata observed=%0h", a_rdata); end
    wdata = 8'h0B;
    tick;
    total++;
    if (a_depth !== 2'd2) begin bad++; $error("FAIL push2_depth observed=%0h", a_depth); end
    total++;
    if (a_full !== 1'b1) begin bad++; $error("FAIL push2_full observed=%0h", a_full); end
    total++;
    if (a_wready !== 1'b0) begin bad++; $error("FAIL push2_wready observed=%0h", a_wready); end
    total++;
    if (a_rdata !== 8'h0A) begin bad++; $error("FAIL push2_rdata observed=%0h", a_rdata); end

    // full: push 0xC refused while 0xA is popped
    wdata = 8'h0C; rready = 1;
    tick;
    total++;
    if (a_depth !== 2'd1) begin bad++; $error("FAIL fullpop_depth observed=%0h", a_depth); end
    total++;
    if (a_full !== 1'b0) begin bad++; $error("FAIL fullpop_full observed=%0h", a_full); end
    total++;
    if (a_rdata !== 8'h0B) begin bad++; $error("FAIL fullpop_rdata observed=%0h", a_rdata); end
    wvalid = 0;
    tick;
    total++;
    if (a_depth !== 2'd0) begin bad++; $error("FAIL drain_depth observed=%0h", a_depth); end
    total++;
    if (a_rvalid !== 1'b0) begin bad++; $error("FAIL drain_rvalid observed=%0h", a_rvalid); end
    total++;
    if (a_rdata !== 8'h00) begin bad++; $error("FAIL drain_rdata observed=%0h", a_rdata); end
    tick;
    total++;
    if (a_depth !== 2'd0) begin bad++; $error("FAIL empty_pop_depth observed=%0h", a_depth); end

    // clr beats a simultaneous push
    rready = 0; wvalid = 1; wdata = 8'h0D;
    tick;
    wdata = 8'h0E;
    tick;
    total++;
    if (a_depth !== 2'd2) begin bad++; $error("FAIL preclr_depth observed=%0h", a_depth); end
    clr = 1; wdata = 8'h0F;
    tick;
    total++;
    if (a_depth !== 2'd0) begin bad++; $error("FAIL clr_depth observed=%0h", a_depth); end
    total++;
    if (a_rvalid !== 1'b0) begin bad++; $error("FAIL clr_rvalid observed=%0h", a_rvalid); end
    clr = 0;

    // simultaneous push/pop with pointer wrap
    wdata = 8'h11;
    tick;
    wdata = 8'h22; rready = 1;
    tick;
    total++;
    if (a_depth !== 2'd1) begin bad++; $error("FAIL pp1_depth observed=%0h", a_depth); end
    total++;
    if (a_rdata !== 8'h22) begin bad++; $error("FAIL pp1_rdata observed=%0h", a_rdata); end
    wdata = 8'h33;
    tick;
    total++;
    if (a_depth !== 2'd1) begin bad++; $error("FAIL pp2_depth observed=%0h", a_depth); end
    total++;
    if (a_rdata !== 8'h33) begin bad++; $error("FAIL pp2_rdata observed=%0h", a_rdata); end
    rready = 0; wdata = 8'h44;
    tick;
    total++;
    if (a_depth !== 2'd2) begin bad++; $error("FAIL pre_rst_depth observed=%0h", a_depth); end

    // asynchronous reset mid-traffic
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (a_depth !== 2'd0) begin bad++; $error("FAIL mid_rst_depth observed=%0h", a_depth); end
    total++;
    if (a_rvalid !== 1'b0) begin bad++; $error("FAIL mid_rst_rvalid observed=%0h", a_rvalid); end
    total++;
    if (a_wready !== 1'b1) begin bad++; $error("FAIL mid_rst_wready observed=%0h", a_wready); end
    wvalid = 0;
    tick;
    rst_n = 1'b1;

    // pass-through FIFO
    b_wvalid = 1; b_wdata = 16'h0005; b_rready = 1;
    #1;
    total++;
    if (b_rvalid !== 1'b1) begin bad++; $error("FAIL pass_rvalid observed=%0h", b_rvalid); end
    total++;
    if (b_rdata !== 16'h0005) begin bad++; $error("FAIL pass_rdata observed=%0h", b_rdata); end
    tick;
    total++;
    if (b_depth !== 2'd0) begin bad++; $error("FAIL pass_depth observed=%0h", b_depth); end
    b_wvalid = 0; b_rready = 0;
    #1;
    total++;
    if (b_rvalid !== 1'b0) begin bad++; $error("FAIL pass_idle_rvalid observed=%0h", b_rvalid); end
    b_wvalid = 1; b_wdata = 16'h0006;
    tick;
    total++;
    if (b_depth !== 2'd1) begin bad++; $error("FAIL pass_store_depth observed=%0h", b_depth); end
    total++;
    if (b_rdata !== 16'h0006) begin bad++; $error("FAIL pass_store_rdata observed=%0h", b_rdata); end
    b_wdata = 16'h0007;
    #1;
    total++;
    if (b_rdata !== 16'h0006) begin bad++; $error("FAIL pass_head_rdata observed=%0h", b_rdata); end
    b_wvalid = 0; b_rready = 1;
    tick;
    total++;
    if (b_depth !== 2'd0) begin bad++; $error("FAIL pass_pop_depth observed=%0h", b_depth); end
    total++;
    if (b_rvalid !== 1'b0) begin bad++; $error("FAIL pass_pop_rvalid observed=%0h", b_rvalid); end
    b_rready = 0;

    // RAM byte-masked write
    m_req = 1; m_write = 1; m_addr = 4'd3; m_wdata = 32'hFFFF_FFFF; m_wmask = 32'hFFFF_FFFF;
    tick;
    m_wdata = 32'h1234_5678; m_wmask = 32'h0000_FF00;
    tick;
    total++;
    if (m_rdata !== 32'h0) begin bad++; $error("FAIL ram_wr_hold observed=%0h", m_rdata); end
    m_write = 0;
    tick;
    total++;
    if (m_rdata !== 32'hFFFF_56FF) begin bad++; $error("FAIL ram_mask_rd observed=%0h", m_rdata); end

    // read data holds across idle and write cycles
    m_write = 1; m_wdata = 32'h11; m_wmask = 32'hFFFF_FFFF;
    tick;
    m_write = 0;
    tick;
    total++;
    if (m_rdata !== 32'h11) begin bad++; $error("FAIL ram_rd_11 observed=%0h", m_rdata); end
    m_req = 0;
    tick;
    total++;
    if (m_rdata !== 32'h11) begin bad++; $error("FAIL ram_idle_hold observed=%0h", m_rdata); end
    m_req = 1; m_write = 1; m_wdata = 32'h22;
    tick;
    total++;
    if (m_rdata !== 32'h11) begin bad++; $error("FAIL ram_wr_nofwd observed=%0h", m_rdata); end
    m_write = 0;
    tick;
    total++;
    if (m_rdata !== 32'h22) begin bad++; $error("FAIL ram_rd_22 observed=%0h", m_rdata); end

    // out-of-range address
    m_write = 1; m_addr = 4'd13; m_wdata = 32'hAAAA_AAAA;
    tick;
    m_write = 0;
    tick;
    total++;
    if (m_rdata !== 32'h0) begin bad++; $error("FAIL ram_oor_rd observed=%0h", m_rdata); end
    m_addr = 4'd3;
    tick;
    total++;
    if (m_rdata !== 32'h22) begin bad++; $error("FAIL ram_rd_after_oor observed=%0h", m_rdata); end
    m_req = 0;

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
